// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the I2C requester arbiter.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int ADDR_W = 7;
  localparam int TO_W   = 10;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr+1, modulo NREQ.
module i2c_rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  win_oh_o,
  output logic [IDX_W-1:0] win_idx_o
);

  int   cand;
  logic found;

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
    cand      = 0;
    // off = NREQ wraps back to ptr itself, so the last grantee is checked last
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(ptr_i) + off) % NREQ;
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        win_oh_o[cand]  = 1'b1;
        win_idx_o       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sequencing NREQ clients onto one I2C byte engine.
// Optional watchdog abort when I2C_ARB_TIMEOUT_EN is defined.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_i,
  input  logic [ADDR_W*NREQ-1:0] req_addr_i,
  input  logic [NREQ-1:0]        req_rw_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic [NREQ-1:0]        done_o,
  output logic                   nack_o,
  output logic                   eng_start_o,
  output logic [ADDR_W-1:0]      eng_addr_o,
  output logic                   eng_rw_o,
  input  logic                   eng_done_i,
  input  logic                   eng_ack_i,
  output logic                   eng_abort_o
);

  localparam int IDX_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > (2**TO_W - 1)) begin : g_bad_cfg
    $error("i2c_req_arbiter: NREQ must be 2..8 and TIMEOUT must fit in TO_W bits");
  end

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [NREQ-1:0]        oh_q, oh_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   rw_q, rw_d;
  logic                   nack_q, nack_d;
  logic                   abort_c;

  logic [NREQ-1:0]              pick_oh;
  logic [IDX_W-1:0]             pick_idx;
  logic [NREQ-1:0][ADDR_W-1:0]  addr_arr;

  assign addr_arr = req_addr_i;

  i2c_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    oh_d    = oh_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    nack_d  = nack_q;
    abort_c = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = ISSUE;
          ptr_d   = pick_idx;
          oh_d    = pick_oh;
          addr_d  = addr_arr[pick_idx];
          rw_d    = req_rw_i[pick_idx];
          nack_d  = 1'b0;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        // engine completion beats a coincident watchdog expiry
        if (eng_done_i) begin
          state_d = DONE;
          nack_d  = ~eng_ack_i;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (cnt_q == TO_W'(TIMEOUT)) begin
          state_d = DONE;
          nack_d  = 1'b1;
          abort_c = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NREQ - 1);
      oh_q    <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      nack_q  <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      oh_q    <= oh_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      nack_q  <= nack_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt_o       = (state_q != IDLE) ? oh_q : '0;
  assign done_o      = (state_q == DONE) ? oh_q : '0;
  assign nack_o      = (state_q == DONE) && nack_q;
  assign eng_start_o = (state_q == ISSUE);
  assign eng_addr_o  = addr_q;
  assign eng_rw_o    = rw_q;

`ifdef I2C_ARB_TIMEOUT_EN
  assign eng_abort_o = abort_c;
`else
  assign eng_abort_o = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed vector bench for i2c_req_arbiter (default build, NREQ=4).
module tb_i2c_req_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_i;
  logic [7*NREQ-1:0] req_addr_i;
  logic [NREQ-1:0]   req_rw_i;
  logic [NREQ-1:0]   gnt_o;
  logic [NREQ-1:0]   done_o;
  logic              nack_o;
  logic              eng_start_o;
  logic [6:0]        eng_addr_o;
  logic              eng_rw_o;
  logic              eng_done_i;
  logic              eng_ack_i;
  logic              eng_abort_o;

  i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT(1023)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .req_addr_i  (req_addr_i),
    .req_rw_i    (req_rw_i),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .nack_o      (nack_o),
    .eng_start_o (eng_start_o),
    .eng_addr_o  (eng_addr_o),
    .eng_rw_o    (eng_rw_o),
    .eng_done_i  (eng_done_i),
    .eng_ack_i   (eng_ack_i),
    .eng_abort_o (eng_abort_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       edone;
    logic       eack;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       nack;
    logic       start;
    logic [6:0] addr;
    logic       rw;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic r, input logic [3:0] rq, input logic ed, input logic ea,
                     input logic [3:0] g, input logic [3:0] d, input logic nk,
                     input logic st, input logic [6:0] a, input logic w);
    vec_t v;
    v.rst = r; v.req = rq; v.edone = ed; v.eack = ea;
    v.gnt = g; v.done = d; v.nack = nk; v.start = st; v.addr = a; v.rw = w;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] g, input logic [3:0] d,
                       input logic nk, input logic st, input logic [6:0] a, input logic w);
    logic [18:0] act, exp;
    act = {gnt_o, done_o, nack_o, eng_start_o, eng_addr_o, eng_rw_o, eng_abort_o};
    exp = {g, d, nk, st, a, w, 1'b0};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got gnt=%b done=%b nack=%b start=%b addr=%h rw=%b abort=%b, want gnt=%b done=%b nack=%b start=%b addr=%h rw=%b abort=0",
               name, gnt_o, done_o, nack_o, eng_start_o, eng_addr_o, eng_rw_o, eng_abort_o,
               g, d, nk, st, a, w);
    end
  endtask

  initial begin
    // req0 0x50 write, req1 0x21 read, req2 0x3A write, req3 0x7F read
    req_addr_i = {7'h7F, 7'h3A, 7'h21, 7'h50};
    req_rw_i   = 4'b1010;
    rst = 1'b1; req_i = '0; eng_done_i = 1'b0; eng_ack_i = 1'b0;

    //   rst req      done ack  gnt      done     nk st addr   rw
    add(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 7'h00, 0); // reset
    add(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 7'h00, 0);
    add(0, 4'b0001, 0, 0, 4'b0001, 4'b0000, 0, 1, 7'h50, 0); // ISSUE req0
    add(0, 4'b0001, 0, 0, 4'b0001, 4'b0000, 0, 0, 7'h50, 0); // WAIT
    add(0, 4'b0001, 1, 1, 4'b0001, 4'b0001, 0, 0, 7'h50, 0); // DONE ack
    add(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 7'h50, 0); // IDLE
    add(0, 4'b1111, 0, 0, 4'b0010, 4'b0000, 0, 1, 7'h21, 1); // rr -> 1
    add(0, 4'b1111, 0, 0, 4'b0010, 4'b0000, 0, 0, 7'h21, 1);
    add(0, 4'b1111, 1, 1, 4'b0010, 4'b0010, 0, 0, 7'h21, 1);
    add(0, 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 0, 7'h21, 1); // gap cycle
    add(0, 4'b1111, 0, 0, 4'b0100, 4'b0000, 0, 1, 7'h3A, 0); // rr -> 2
    add(0, 4'b1111, 1, 0, 4'b0100, 4'b0000, 0, 0, 7'h3A, 0); // done in ISSUE ignored
    add(0, 4'b1111, 1, 0, 4'b0100, 4'b0100, 1, 0, 7'h3A, 0); // NACK
    add(0, 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 0, 7'h3A, 0);
    add(0, 4'b1111, 0, 0, 4'b1000, 4'b0000, 0, 1, 7'h7F, 1); // rr -> 3
    add(0, 4'b1111, 0, 0, 4'b1000, 4'b0000, 0, 0, 7'h7F, 1);
    add(0, 4'b1111, 1, 1, 4'b1000, 4'b1000, 0, 0, 7'h7F, 1);
    add(0, 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 0, 7'h7F, 1);
    add(0, 4'b1111, 0, 0, 4'b0001, 4'b0000, 0, 1, 7'h50, 0); // wrap -> 0
    add(0, 4'b0000, 0, 0, 4'b0001, 4'b0000, 0, 0, 7'h50, 0); // req dropped
    add(0, 4'b0000, 0, 0, 4'b0001, 4'b0000, 0, 0, 7'h50, 0);
    add(0, 4'b0000, 1, 1, 4'b0001, 4'b0001, 0, 0, 7'h50, 0); // still completes
    add(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 7'h50, 0);
    add(0, 4'b0100, 0, 0, 4'b0100, 4'b0000, 0, 1, 7'h3A, 0);
    add(0, 4'b0100, 0, 0, 4'b0100, 4'b0000, 0, 0, 7'h3A, 0); // WAIT
    add(1, 4'b0100, 1, 1, 4'b0000, 4'b0000, 0, 0, 7'h00, 0); // rst wins, no done
    add(0, 4'b0100, 0, 0, 4'b0100, 4'b0000, 0, 1, 7'h3A, 0); // fresh grant req2
    add(0, 4'b0000, 0, 0, 4'b0100, 4'b0000, 0, 0, 7'h3A, 0);
    add(0, 4'b0000, 1, 1, 4'b0100, 4'b0100, 0, 0, 7'h3A, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 7'h3A, 0);
    add(0, 4'b0011, 0, 0, 4'b0001, 4'b0000, 0, 1, 7'h50, 0); // ptr=2 -> 3,0 -> 0
    add(0, 4'b0011, 0, 0, 4'b0001, 4'b0000, 0, 0, 7'h50, 0);
    add(0, 4'b0011, 1, 1, 4'b0001, 4'b0001, 0, 0, 7'h50, 0);
    add(0, 4'b0011, 0, 0, 4'b0000, 4'b0000, 0, 0, 7'h50, 0);
    add(0, 4'b0011, 0, 0, 4'b0010, 4'b0000, 0, 1, 7'h21, 1); // req1 not starved
    add(0, 4'b0011, 0, 0, 4'b0010, 4'b0000, 0, 0, 7'h21, 1);
    add(0, 4'b0011, 1, 1, 4'b0010, 4'b0010, 0, 0, 7'h21, 1);
    add(0, 4'b0011, 0, 0, 4'b0000, 4'b0000, 0, 0, 7'h21, 1);
    add(0, 4'b0001, 0, 0, 4'b0001, 4'b0000, 0, 1, 7'h50, 0); // ISSUE req0

    for (int i = 0; i < vecs.size(); i++) begin
      rst        = vecs[i].rst;
      req_i      = vecs[i].req;
      eng_done_i = vecs[i].edone;
      eng_ack_i  = vecs[i].eack;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].done, vecs[i].nack,
            vecs[i].start, vecs[i].addr, vecs[i].rw);
    end

    // long engine stall: WAIT holds grant, no done, no abort in default build
    eng_done_i = 1'b0; eng_ack_i = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d", c), 4'b0001, 4'b0000, 1'b0, 1'b0, 7'h50, 1'b0);
    end
    req_i = 4'b0000; eng_done_i = 1'b1; eng_ack_i = 1'b0;
    @(posedge clk); #1;
    check("stall_done", 4'b0001, 4'b0001, 1'b1, 1'b0, 7'h50, 1'b0);
    eng_done_i = 1'b1; eng_ack_i = 1'b1;  // done outside WAIT must be ignored
    @(posedge clk); #1;
    check("idle_after", 4'b0000, 4'b0000, 1'b0, 1'b0, 7'h50, 1'b0);
    eng_done_i = 1'b0;
    @(posedge clk); #1;
    check("idle_hold", 4'b0000, 4'b0000, 1'b0, 1'b0, 7'h50, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
